// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time and hands
// fetched words to decode through a one-entry buffer. Define IF_ALIGN_CHECK_EN to fault on misaligned redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        fault_o
);

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        req_w;
    logic        redirect_take;
    logic        capture;
    logic [31:0] redirect_target;
    state_e      after_redirect_state;
    state_e      after_drop_state;

    // Redirects are ignored while booting; everywhere else they win over everything.
    assign redirect_take = redirect_valid_i && (state_q != ST_BOOT);

`ifdef IF_ALIGN_CHECK_EN
    assign redirect_target      = redirect_pc_i;
    assign after_redirect_state = (redirect_pc_i[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
    // A dropped response after a misaligned redirect lands in FAULT; pc_q already holds that target.
    assign after_drop_state     = (pc_q[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
`else
    assign redirect_target      = redirect_pc_i & 32'hFFFF_FFFC;
    assign after_redirect_state = ST_REQ;
    assign after_drop_state     = ST_REQ;
`endif

    assign capture = (state_q == ST_WAIT) && imem_rvalid_i && !drop_q && !redirect_take;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // Next-state, PC and drop tracking
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_take) begin
                    pc_d = redirect_target;
                    if (req_w && imem_gnt_i) begin
                        // The old-address request is already in flight; swallow its response.
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = after_redirect_state;
                    end
                end else if (req_w && imem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_take) begin
                    pc_d = redirect_target;
                    if (imem_rvalid_i) begin
                        drop_d  = 1'b0;
                        state_d = after_redirect_state;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = after_drop_state;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end
                end
            end
`ifdef IF_ALIGN_CHECK_EN
            ST_FAULT: begin
                if (redirect_take) begin
                    pc_d    = redirect_target;
                    state_d = after_redirect_state;
                end
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output buffer: flush beats capture, capture beats drain.
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (redirect_take) begin
            inst_valid_d = 1'b0;
        end else if (capture) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata_i;
            inst_pc_d    = pc_q;
        end else if (inst_valid_q && inst_ready_i) begin
            inst_valid_d = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        req_w = 1'b0;
        case (state_q)
            ST_REQ:  req_w = !inst_valid_q || inst_ready_i;
            default: req_w = 1'b0;
        endcase
    end

`ifdef IF_ALIGN_CHECK_EN
    assign fault_o = (state_q == ST_FAULT);
`else
    assign fault_o = 1'b0;
`endif

    assign imem_req_o   = req_w;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus hand-written reset sequences.
// Expectations for misaligned redirects follow IF_ALIGN_CHECK_EN when it is defined.
module tb_if_fetch;

    logic        clk;
    logic        rstn;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        fault_o;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    if_fetch dut (
        .clk              (clk),
        .rstn             (rstn),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc_o),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i),
        .fault_o          (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_fault;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic av(input logic rv, input logic [31:0] rpc, input logic gnt, input logic rvalid,
                      input logic [31:0] rdata, input logic ready, input logic e_req,
                      input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_inst,
                      input logic [31:0] e_ipc, input logic e_fault);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        v.e_fault = e_fault;
        vq.push_back(v);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0;
        redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b0;

        //  rv  rpc           gnt rvl rdata         rdy | req addr          iv  inst          ipc           flt
        av(0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h3000,      0, 32'h0,        32'h0,        0); // 0 BOOT
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3000,      0, 32'h0,        32'h0,        0); // 1
        av(0, 32'h0,          0, 1, 32'h2408_0005,  1,   0, 32'h3000,      0, 32'h0,        32'h0,        0); // 2
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3004,      1, 32'h2408_0005, 32'h3000,    0); // 3
        av(0, 32'h0,          0, 1, 32'h2409_0007,  1,   0, 32'h3004,      0, 32'h2408_0005, 32'h3000,    0); // 4
        av(0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h3008,      1, 32'h2409_0007, 32'h3004,    0); // 5 stall
        av(0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h3008,      1, 32'h2409_0007, 32'h3004,    0); // 6
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3008,      1, 32'h2409_0007, 32'h3004,    0); // 7 resume
        av(1, 32'h3040,       0, 0, 32'h0,          1,   0, 32'h3008,      0, 32'h2409_0007, 32'h3004,    0); // 8 redirect in WAIT
        av(0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1,   0, 32'h3040,      0, 32'h2409_0007, 32'h3004,    0); // 9 stale drop
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3040,      0, 32'h2409_0007, 32'h3004,    0); // 10
        av(0, 32'h0,          0, 1, 32'h1111_1111,  1,   0, 32'h3040,      0, 32'h2409_0007, 32'h3004,    0); // 11
        av(1, 32'h3080,       0, 0, 32'h0,          0,   0, 32'h3044,      1, 32'h1111_1111, 32'h3040,    0); // 12 flush
        av(1, 32'h3100,       1, 0, 32'h0,          0,   1, 32'h3080,      0, 32'h1111_1111, 32'h3040,    0); // 13 redirect+gnt
        av(0, 32'h0,          0, 1, 32'h2222_2222,  0,   0, 32'h3100,      0, 32'h1111_1111, 32'h3040,    0); // 14 stale drop
        av(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h3100,      0, 32'h1111_1111, 32'h3040,    0); // 15
        av(0, 32'h0,          0, 1, 32'h3333_3333,  0,   0, 32'h3100,      0, 32'h1111_1111, 32'h3040,    0); // 16
        av(1, 32'h3042,       0, 0, 32'h0,          1,   1, 32'h3104,      1, 32'h3333_3333, 32'h3100,    0); // 17 misaligned
        av(0, 32'h0,          0, 0, 32'h0,          1,   !ALIGN, ALIGN ? 32'h3042 : 32'h3040,
                                                                           0, 32'h3333_3333, 32'h3100,    ALIGN); // 18
        av(1, 32'h3100,       0, 0, 32'h0,          1,   !ALIGN, ALIGN ? 32'h3042 : 32'h3040,
                                                                           0, 32'h3333_3333, 32'h3100,    ALIGN); // 19
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3100,      0, 32'h3333_3333, 32'h3100,    0); // 20
        av(0, 32'h0,          0, 1, 32'h4444_4444,  1,   0, 32'h3100,      0, 32'h3333_3333, 32'h3100,    0); // 21
        av(0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h3104,      1, 32'h4444_4444, 32'h3100,    0); // 22
        av(1, 32'hFFFF_FFFC,  0, 0, 32'h0,          0,   0, 32'h3104,      1, 32'h4444_4444, 32'h3100,    0); // 23
        av(0, 32'h0,          1, 0, 32'h0,          0,   1, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'h3100,    0); // 24
        av(0, 32'h0,          0, 1, 32'h5555_5555,  0,   0, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'h3100,    0); // 25
        av(0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,         1, 32'h5555_5555, 32'hFFFF_FFFC, 0); // 26 wrap
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0,         1, 32'h5555_5555, 32'hFFFF_FFFC, 0); // 27
        av(1, 32'h3200,       0, 1, 32'h6666_6666,  1,   0, 32'h0,         0, 32'h5555_5555, 32'hFFFF_FFFC, 0); // 28 redirect+rvalid
        av(0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h3200,      0, 32'h5555_5555, 32'hFFFF_FFFC, 0); // 29
        av(0, 32'h0,          0, 1, 32'h7777_7777,  1,   0, 32'h3200,      0, 32'h5555_5555, 32'hFFFF_FFFC, 0); // 30
        av(0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h3204,      1, 32'h7777_7777, 32'h3200,    0); // 31

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",    pc_o,         32'h3000);
        check("rst_req",   {31'h0, imem_req_o},   32'h0);
        check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rst_inst",  inst_o,       32'h0);
        check("rst_ipc",   inst_pc_o,    32'h0);
        check("rst_fault", {31'h0, fault_o},      32'h0);
        rstn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            redirect_valid_i = vq[i].rv;
            redirect_pc_i    = vq[i].rpc;
            imem_gnt_i       = vq[i].gnt;
            imem_rvalid_i    = vq[i].rvalid;
            imem_rdata_i     = vq[i].rdata;
            inst_ready_i     = vq[i].ready;
            #1;
            $display("vec %0d: req=%0b addr=%h valid=%0b inst=%h ipc=%h fault=%0b",
                     i, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fault_o);
            check($sformatf("v%0d_req", i),   {31'h0, imem_req_o},   {31'h0, vq[i].e_req});
            check($sformatf("v%0d_addr", i),  imem_addr_o,           vq[i].e_addr);
            check($sformatf("v%0d_pc", i),    pc_o,                  vq[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, vq[i].e_iv});
            check($sformatf("v%0d_inst", i),  inst_o,                vq[i].e_inst);
            check($sformatf("v%0d_ipc", i),   inst_pc_o,             vq[i].e_ipc);
            check($sformatf("v%0d_fault", i), {31'h0, fault_o},      {31'h0, vq[i].e_fault});
            @(posedge clk);
            #1;
        end

        // Mid-operation reset while a request is outstanding.
        redirect_valid_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b1; imem_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        imem_gnt_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        $display("mid-reset: pc=%h req=%0b valid=%0b", pc_o, imem_req_o, inst_valid_o);
        check("mrst_pc",    pc_o,                  32'h3000);
        check("mrst_req",   {31'h0, imem_req_o},   32'h0);
        check("mrst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("mrst_inst",  inst_o,                32'h0);
        check("mrst_ipc",   inst_pc_o,             32'h0);

        // Late response arrives across reset release and BOOT; it must be ignored.
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8888_8888;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("boot_req",   {31'h0, imem_req_o},   32'h0);
        cnt = 0;
        while (!imem_req_o && cnt < 8) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        imem_rvalid_i = 1'b0;
        $display("post-reset: first request after %0d cycles, addr=%h", cnt, imem_addr_o);
        check("first_req_latency", cnt,                    32'd1);
        check("late_rsp_valid",    {31'h0, inst_valid_o},  32'h0);
        check("late_rsp_addr",     imem_addr_o,            32'h3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
